// File: rtl/key_matrix_pkg.sv
// Shared constants for the key matrix scanner: matrix geometry, address fields, read bits.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package key_matrix_pkg;

  localparam int ROW_COUNT = 8;
  localparam int COL_COUNT = 8;
  localparam int KEY_COUNT = ROW_COUNT * COL_COUNT;

  // Word-address fields: key index is {row, col} = address[7:2].
  localparam int ROW_LSB        = 5;
  localparam int COL_LSB        = 2;
  localparam int STATUS_SEL_BIT = 8;

  // readData bit positions.
  localparam int STABLE_BIT    = 0;
  localparam int EVENT_BIT     = 1;
  localparam int ANY_EVENT_BIT = 8;

  // Active-low one-hot drive pattern for a row.
  function automatic logic [ROW_COUNT-1:0] row_drive(input logic [2:0] r);
    return ~(8'b1 << r);
  endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// Per-key debouncer: flips stable after DEBOUNCE_SCANS consecutive disagreeing samples.
// Latency: stable/eventFlag update on the edge of the qualifying sample.
// Backpressure: none; a set event wins over a same-cycle clear.
module key_debounce_cell #(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sample,
  input  logic sampleEnable,
  input  logic clearEvent,
  output logic stable,
  output logic eventFlag
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          toggle;
  logic          set_event;

  assign cnt_inc   = cnt + CW'(1);
  assign toggle    = sampleEnable && (sample != stable) && (cnt_inc == CW'(DEBOUNCE_SCANS));
  assign set_event = toggle && !stable;

  // Count disagreeing samples, flip stable on the Nth, latch press events until read.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      stable    <= 1'b0;
      eventFlag <= 1'b0;
    end else begin
      if (sampleEnable) begin
        if (sample == stable) begin
          cnt <= '0;
        end else if (toggle) begin
          cnt    <= '0;
          stable <= ~stable;
        end else begin
          cnt <= cnt_inc;
        end
      end
      eventFlag <= set_event | (eventFlag & ~clearEvent);
    end
  end

endmodule

// File: rtl/key_matrix_peripheral.sv
// Read-only 8x8 key matrix scanner: row drive, column sync, 64 debouncers, bus read mux.
// Latency: reads return one clock after isTarget; column change reaches the sampler in 2 clocks.
// Backpressure: none; a read is accepted on every cycle isTarget is high.
module key_matrix_peripheral
  import key_matrix_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 256,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        isTarget,
  input  logic [27:0] address,
  input  logic [7:0]  keyMatrixColumn,
  output logic [7:0]  keyMatrixRow,
  output logic [31:0] readData
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  logic [7:0]           sync1;
  logic [7:0]           sync2;
  logic [2:0]           row;
  logic [SW-1:0]        settle_cnt;
  logic                 scan_tick;
  logic [KEY_COUNT-1:0] stable_q;
  logic [KEY_COUNT-1:0] event_q;
  logic [KEY_COUNT-1:0] clear_sel;
  logic [5:0]           key_idx;
  logic [2:0]           addr_row;
  logic [31:0]          read_next;
  logic                 unused_addr_bits;

  assign scan_tick        = (settle_cnt == SW'(SETTLE_CYCLES - 1));
  assign key_idx          = address[ROW_LSB+2:COL_LSB];
  assign addr_row         = address[ROW_LSB+2:ROW_LSB];
  assign unused_addr_bits = ^{address[27:9], address[1:0]};

  // Two-flop synchronizer on the asynchronous column lines; idle level is released (1).
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 8'hFF;
      sync2 <= 8'hFF;
    end else begin
      sync1 <= keyMatrixColumn;
      sync2 <= sync1;
    end
  end

  // Settle counter and row pointer; the drive register trails the pointer by one clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      row          <= 3'd0;
      settle_cnt   <= '0;
      keyMatrixRow <= 8'hFE;
    end else begin
      keyMatrixRow <= row_drive(row);
      if (scan_tick) begin
        settle_cnt <= '0;
        row        <= row + 3'd1;
      end else begin
        settle_cnt <= settle_cnt + SW'(1);
      end
    end
  end

  genvar gr, gc;
  generate
    for (gr = 0; gr < ROW_COUNT; gr++) begin : g_row
      for (gc = 0; gc < COL_COUNT; gc++) begin : g_col
        key_debounce_cell #(
          .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
        ) u_cell (
          .clk          (clk),
          .reset        (reset),
          .sample       (~sync2[gc]),
          .sampleEnable (scan_tick && (row == 3'(gr))),
          .clearEvent   (clear_sel[gr*COL_COUNT+gc]),
          .stable       (stable_q[gr*COL_COUNT+gc]),
          .eventFlag    (event_q[gr*COL_COUNT+gc])
        );
      end
    end
  endgenerate

  // Key-register reads clear the addressed key's event; status reads clear nothing.
  always_comb begin
    clear_sel = '0;
    if (isTarget && !address[STATUS_SEL_BIT]) begin
      clear_sel[key_idx] = 1'b1;
    end
  end

  // Read mux: single-key view or whole-row status with the any-event summary.
  always_comb begin
    read_next = 32'h0;
    if (address[STATUS_SEL_BIT]) begin
      read_next[7:0]           = stable_q[{addr_row, 3'b000} +: 8];
      read_next[ANY_EVENT_BIT] = |event_q;
    end else begin
      read_next[STABLE_BIT] = stable_q[key_idx];
      read_next[EVENT_BIT]  = event_q[key_idx];
    end
  end

  // Registered read data, held while the peripheral is not addressed.
  always_ff @(posedge clk) begin
    if (reset) begin
      readData <= 32'h0;
    end else if (isTarget) begin
      readData <= read_next;
    end
  end

endmodule

// File: tb/tb_key_matrix_peripheral.sv
module tb_key_matrix_peripheral;

  localparam int S = 4;
  localparam int D = 2;
  localparam int FRAME = 8 * S;

  logic        clk = 1'b0;
  logic        reset;
  logic        isTarget;
  logic [27:0] address;
  logic [7:0]  keyMatrixColumn;
  logic [7:0]  keyMatrixRow;
  logic [31:0] readData;

  logic [63:0] press;   // physical key state, index row*8+col

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  key_matrix_peripheral #(
    .SETTLE_CYCLES  (S),
    .DEBOUNCE_SCANS (D)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .isTarget        (isTarget),
    .address         (address),
    .keyMatrixColumn (keyMatrixColumn),
    .keyMatrixRow    (keyMatrixRow),
    .readData        (readData)
  );

  // Matrix wiring: a pressed key pulls its column low while its row is driven low.
  function automatic logic [7:0] col_of(input logic [63:0] p, input logic [7:0] drv);
    logic [7:0] col;
    col = 8'hFF;
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 8; r++)
        if (p[r*8+c] && !drv[r]) col[c] = 1'b0;
    return col;
  endfunction

  assign keyMatrixColumn = col_of(press, keyMatrixRow);

  // Expected row drive after k clocks out of reset: row pointer advances every S clocks,
  // the drive register shows the pointer value from one clock earlier.
  function automatic logic [7:0] kmr_of(input int k);
    int r;
    r = (k == 0) ? 0 : ((k - 1) / S) % 8;
    return ~(8'b1 << r);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          mk;          // clocks since reset
  logic [7:0]  m_s1, m_s2;  // column value seen one / two clocks ago
  logic [63:0] m_stable, m_event;
  int          m_cnt [64];
  logic [31:0] m_rd;
  bit          started = 0;

  always @(posedge clk) begin
    logic [7:0]  col;
    logic [63:0] set;
    int          clr;
    int          r, key;
    logic        p;
    if (reset) begin
      mk = 0; m_s1 = 8'hFF; m_s2 = 8'hFF;
      m_stable = '0; m_event = '0; m_rd = 32'h0;
      for (int i = 0; i < 64; i++) m_cnt[i] = 0;
      started = 1;
    end else if (started) begin
      col = col_of(press, kmr_of(mk));
      set = '0;
      clr = -1;
      if (isTarget) begin
        m_rd = 32'h0;
        if (address[8]) begin
          r = int'(address[7:5]);
          for (int c = 0; c < 8; c++) m_rd[c] = m_stable[r*8+c];
          m_rd[8] = |m_event;
        end else begin
          key = int'(address[7:2]);
          m_rd[0] = m_stable[key];
          m_rd[1] = m_event[key];
          clr = key;
        end
      end
      if (mk % S == S - 1) begin
        r = (mk / S) % 8;
        for (int c = 0; c < 8; c++) begin
          key = r * 8 + c;
          p = ~m_s2[c];
          if (p == m_stable[key]) m_cnt[key] = 0;
          else begin
            m_cnt[key]++;
            if (m_cnt[key] == D) begin
              m_cnt[key] = 0;
              m_stable[key] = p;
              if (p) set[key] = 1'b1;
            end
          end
        end
      end
      if (clr >= 0) m_event[clr] = 1'b0;
      m_event = m_event | set;
      m_s2 = m_s1;
      m_s1 = col;
      mk++;
    end
    #1;
    if (started) begin
      check("row_drive", {24'h0, keyMatrixRow}, {24'h0, kmr_of(mk)});
      check("read_data", readData, m_rd);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic rd(input logic [27:0] a, input logic [31:0] exp, input string name);
    isTarget = 1'b1;
    address  = a;
    @(negedge clk);
    isTarget = 1'b0;
    check(name, readData, exp);
  endtask

  task automatic align_frame();
    for (int n = 0; n < 2 * FRAME && (mk % FRAME) != 0; n++) @(negedge clk);
    check("frame_align", mk % FRAME, 0);
  endtask

  initial begin
    int base;
    reset = 1'b1; isTarget = 1'b0; address = '0; press = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_row", {24'h0, keyMatrixRow}, 32'hFE);
    check("reset_rd", readData, 32'h0);

    // Row stepping FE, FD, ... 7F, FE
    for (int i = 0; i < 9; i++) begin
      logic [7:0] one;
      one = 8'b1;
      repeat (S) @(posedge clk);
      #1;
      check("row_step", {24'h0, keyMatrixRow}, {24'h0, ~(one << (i % 8))});
    end
    @(negedge clk);

    // Press key (2,5)
    press[2*8+5] = 1'b1;
    repeat (100) @(negedge clk);
    rd(28'd84, 32'h3, "press_read");
    rd(28'd84, 32'h1, "press_reread");
    press[2*8+5] = 1'b0;
    repeat (100) @(negedge clk);

    // Bounce: key (0,0) visible for exactly one row-0 sample
    align_frame();
    press[0] = 1'b1;
    repeat (16) @(negedge clk);
    press[0] = 1'b0;
    repeat (100) @(negedge clk);
    rd(28'd256, 32'h0, "bounce_status");

    // Row status with two keys on row 7
    press[7*8+0] = 1'b1;
    press[7*8+7] = 1'b1;
    repeat (100) @(negedge clk);
    rd(28'd480, 32'h181, "status_row7");
    rd(28'd480, 32'h181, "status_row7_again");
    rd(28'd224, 32'h3, "key_7_0");
    rd(28'd252, 32'h3, "key_7_7");
    press[7*8+0] = 1'b0;
    press[7*8+7] = 1'b0;
    repeat (100) @(negedge clk);

    // Set-wins collision on key (3,1): read lands on the toggling edge
    align_frame();
    base = mk;
    press[3*8+1] = 1'b1;
    for (int n = 0; n < 3 * FRAME && mk != base + FRAME + 3 * S + S - 1; n++) @(negedge clk);
    check("collide_align", mk - base, FRAME + 3 * S + S - 1);
    rd(28'd100, 32'h0, "collide_read");
    rd(28'd100, 32'h3, "collide_next");
    press[3*8+1] = 1'b0;
    repeat (100) @(negedge clk);

    // Reset mid-debounce on key (4,2)
    press[4*8+2] = 1'b1;
    repeat (FRAME) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    press[4*8+2] = 1'b0;
    check("pulse_row", {24'h0, keyMatrixRow}, 32'hFE);
    check("pulse_rd", readData, 32'h0);
    repeat (100) @(negedge clk);
    rd(28'd136, 32'h0, "reset_mid_debounce");

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
